// File: rtl/debug_reg_dump_if.sv
// Byte stream from the register dumper to the debug UART transmitter.
// Valid/ready handshake; a byte moves when both are high at a clock edge.
interface debug_reg_dump_if #(
  parameter int NB_BYTE = 8
);
  logic [NB_BYTE-1:0] tx_data;
  logic               tx_valid;
  logic               tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/debug_reg_dump.sv
// Sweeps the register-file debug port and streams every register out
// as bytes, MSB first, in ascending address order.
module debug_reg_dump #(
  parameter int NB_DATA  = 32,
  parameter int NB_REG   = 5,
  parameter int SIZE_REG = 32,
  parameter int NB_BYTE  = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  output logic [NB_REG-1:0]  o_address_read_debug,
  input  logic [NB_DATA-1:0] i_data_read_debug,
  debug_reg_dump_if.master   tx,
  output logic               o_busy,
  output logic               o_done
);

  localparam int NUM_BYTES = NB_DATA / NB_BYTE;
  localparam int NB_CNT =
    (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [NB_CNT-1:0] LAST_BYTE =
    NB_CNT'(NUM_BYTES - 1);
  localparam logic [NB_REG-1:0] LAST_REG =
    NB_REG'(SIZE_REG - 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    CAPTURE,
    SEND,
    DONE
  } state_t;

  state_t              state, state_n;
  logic [NB_REG-1:0]   reg_idx, reg_idx_n;
  logic [NB_CNT-1:0]   byte_cnt, byte_cnt_n;
  logic [NB_DATA-1:0]  shreg, shreg_n;
  logic [NB_REG-1:0]   addr_n;
  logic [NB_BYTE-1:0]  data_n;
  logic                valid_n;
  logic                busy_n;
  logic                done_n;
  logic                accept;

  assign accept = tx.tx_valid && tx.tx_ready;

  always_comb begin
    state_n    = state;
    reg_idx_n  = reg_idx;
    byte_cnt_n = byte_cnt;
    shreg_n    = shreg;
    addr_n     = o_address_read_debug;
    data_n     = tx.tx_data;
    valid_n    = tx.tx_valid;
    busy_n     = o_busy;
    done_n     = 1'b0;
    unique case (state)
      IDLE: begin
        busy_n  = 1'b0;
        valid_n = 1'b0;
        if (i_start) begin
          reg_idx_n = '0;
          addr_n    = '0;
          busy_n    = 1'b1;
          state_n   = ADDR;
        end
      end
      ADDR: begin
        busy_n  = 1'b1;
        state_n = CAPTURE;
      end
      CAPTURE: begin
        shreg_n    = i_data_read_debug;
        byte_cnt_n = '0;
        data_n     = i_data_read_debug[NB_DATA-1 -: NB_BYTE];
        valid_n    = 1'b1;
        state_n    = SEND;
      end
      SEND: begin
        if (accept) begin
          if (byte_cnt == LAST_BYTE) begin
            valid_n = 1'b0;
            if (reg_idx == LAST_REG) begin
              busy_n  = 1'b0;
              done_n  = 1'b1;
              state_n = DONE;
            end else begin
              reg_idx_n = reg_idx + 1'b1;
              addr_n    = reg_idx + 1'b1;
              state_n   = ADDR;
            end
          end else begin
            // next byte is the one just below the outgoing MSB byte
            shreg_n    = shreg << NB_BYTE;
            data_n     = shreg[NB_DATA-NB_BYTE-1 -: NB_BYTE];
            byte_cnt_n = byte_cnt + 1'b1;
          end
        end
      end
      DONE: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        valid_n = 1'b0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state                <= IDLE;
      reg_idx              <= '0;
      byte_cnt             <= '0;
      shreg                <= '0;
      o_address_read_debug <= '0;
      tx.tx_data           <= '0;
      tx.tx_valid          <= 1'b0;
      o_busy               <= 1'b0;
      o_done               <= 1'b0;
    end else begin
      state                <= state_n;
      reg_idx              <= reg_idx_n;
      byte_cnt             <= byte_cnt_n;
      shreg                <= shreg_n;
      o_address_read_debug <= addr_n;
      tx.tx_data           <= data_n;
      tx.tx_valid          <= valid_n;
      o_busy               <= busy_n;
      o_done               <= done_n;
    end
  end

endmodule

// File: tb/tb_debug_reg_dump.sv
// Bench for debug_reg_dump: register-file model, expected byte queue
// built from the register contents, randomized transmitter readiness.
module tb_debug_reg_dump;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_start;
  logic [4:0]  o_address_read_debug;
  logic [31:0] i_data_read_debug;
  logic        o_busy;
  logic        o_done;

  logic [31:0] rf [32];

  int n_chk;
  int n_fail;

  debug_reg_dump_if #(.NB_BYTE(8)) tx_if ();

  debug_reg_dump dut (
    .i_clk                (i_clk),
    .i_rst_n              (i_rst_n),
    .i_start              (i_start),
    .o_address_read_debug (o_address_read_debug),
    .i_data_read_debug    (i_data_read_debug),
    .tx                   (tx_if.master),
    .o_busy               (o_busy),
    .o_done               (o_done)
  );

  // zero-latency register file read
  assign i_data_read_debug = rf[o_address_read_debug];

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    int          pct;
    logic [31:0] base;
    int          exp_done;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] base);
    for (int k = 0; k < 32; k++) rf[k] = base | 32'(k);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_addr"}, 32'(o_address_read_debug), 0);
    chk({tag, "_data"}, 32'(tx_if.tx_data), 0);
    chk({tag, "_valid"}, 32'(tx_if.tx_valid), 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_done"}, 32'(o_done), 0);
  endtask

  // Returns right after the sample that shows o_done (done_e = edge
  // number counted from the start edge), or -1 on reset/timeout.
  task automatic run_dump(input int pct, input bit hold,
                          input int wr_reg, input logic [31:0] wr_val,
                          input int rst_at, output int done_e);
    logic [7:0]  q[$];
    logic [7:0]  d;
    logic [7:0]  exp_b;
    logic        v;
    logic        r;
    int          got;
    bit          written;
    for (int k = 0; k < 32; k++)
      for (int b = 3; b >= 0; b--)
        q.push_back(rf[k][8*b +: 8]);
    got = 0;
    written = 0;
    done_e = -1;
    i_start = 1'b1;
    step();
    if (!hold) i_start = 1'b0;
    for (int e = 1; e < 4000; e++) begin
      v = tx_if.tx_valid;
      d = tx_if.tx_data;
      r = ($urandom_range(99) < pct);
      if (rst_at >= 0 && v && got == rst_at) begin
        tx_if.tx_ready = 1'b1;
        i_rst_n = 1'b0;
        step();
        check_reset_outputs("mid_reset");
        i_rst_n = 1'b1;
        tx_if.tx_ready = 1'b0;
        return;
      end
      tx_if.tx_ready = r;
      step();
      if (e == 1) chk("busy_after_start", 32'(o_busy), 1);
      if (v && r) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL extra_byte: got %h expected none", d);
        end else begin
          exp_b = q.pop_front();
          chk("byte", 32'(d), 32'(exp_b));
        end
        got++;
      end else if (v) begin
        chk("stall_hold", {23'd0, tx_if.tx_valid, tx_if.tx_data},
            {23'd0, 1'b1, d});
      end
      if (wr_reg >= 0 && !written && got == wr_reg * 4 + 1) begin
        rf[wr_reg] = wr_val;
        written = 1;
      end
      if (o_done) begin
        chk("done_valid_excl", 32'(tx_if.tx_valid), 0);
        chk("done_busy", 32'(o_busy), 0);
        chk("bytes_left", 32'(q.size()), 0);
        chk("byte_count", 32'(got), 128);
        done_e = e;
        return;
      end
      if (!o_busy) begin
        n_chk++;
        n_fail++;
        $display("FAIL busy_drop: got 0 expected 1 at edge %0d", e);
        return;
      end
    end
    n_chk++;
    n_fail++;
    $display("FAIL timeout: no done, got %0d bytes expected 128", got);
  endtask

  vec_t tbl[3];
  int   de;

  initial begin
    n_chk = 0;
    n_fail = 0;
    i_rst_n = 1'b0;
    i_start = 1'b0;
    tx_if.tx_ready = 1'b0;
    fill(32'hA500_0000);
    step();
    step();
    check_reset_outputs("reset");
    i_rst_n = 1'b1;
    step();

    tbl[0] = '{100, 32'hA500_0000, 192};
    tbl[1] = '{30, 32'hA500_0000, 0};
    tbl[2] = '{60, $urandom() & 32'hFFFF_FF00, 0};

    for (int t = 0; t < 3; t++) begin
      fill(tbl[t].base);
      run_dump(tbl[t].pct, 0, -1, 32'd0, -1, de);
      if (tbl[t].exp_done > 0)
        chk("done_edge", 32'(de), 32'(tbl[t].exp_done));
      step();
      chk("done_one_cycle", 32'(o_done), 0);
      step();
    end

    // snapshot: reg 3 rewritten during its own SEND phase
    fill(32'hA500_0000);
    run_dump(50, 0, 3, 32'h1122_3344, -1, de);
    step();
    step();
    chk("snap_rf3", rf[3], 32'h1122_3344);
    run_dump(100, 0, -1, 32'd0, -1, de);
    chk("snap_done_edge", 32'(de), 192);
    step();
    step();

    // reset while reg 7 byte 2 is presented
    fill(32'hA500_0000);
    run_dump(60, 0, -1, 32'd0, 30, de);
    for (int i = 0; i < 4; i++) begin
      chk("post_reset_done", 32'(o_done), 0);
      chk("post_reset_busy", 32'(o_busy), 0);
      step();
    end
    run_dump(100, 0, -1, 32'd0, -1, de);
    chk("restart_done_edge", 32'(de), 192);
    step();
    step();

    // start held through the dump and through the DONE cycle
    run_dump(100, 1, -1, 32'd0, -1, de);
    chk("held_done_edge", 32'(de), 192);
    step();
    i_start = 1'b0;
    chk("held_done_cleared", 32'(o_done), 0);
    chk("held_no_retrigger", 32'(o_busy), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("idle_stays", {30'd0, o_busy, tx_if.tx_valid}, 0);
    end
    run_dump(100, 0, -1, 32'd0, -1, de);
    chk("after_idle_done_edge", 32'(de), 192);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
